// File: rtl/airi5c_spi_fifo_if.sv
// Bus-side handshake bundle for airi5c_spi_fifo: strobes, data and status flags.
// The master modport is the producer/consumer; the slave modport is the FIFO itself.
interface airi5c_spi_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  clear;
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic [ADDR_WIDTH:0]   size;
  logic [ADDR_WIDTH:0]   threshold;
  logic                  above_thr;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clear, push, data_in, pop, threshold,
    input  data_out, empty, full, size, above_thr, overflow, underflow
  );

  modport slave (
    input  clear, push, data_in, pop, threshold,
    output data_out, empty, full, size, above_thr, overflow, underflow
  );
endinterface

// File: rtl/airi5c_spi_fifo.sv
// First-word-fall-through FIFO between the SPI register interface and the SPI master,
// with occupancy, watermark and sticky overflow/underflow status.
module airi5c_spi_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic              clk,
  input  logic              n_reset,
  airi5c_spi_fifo_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic [ADDR_WIDTH:0]   w_cnt_next;

  assign w_empty   = (r_cnt == {(ADDR_WIDTH+1){1'b0}});
  assign w_full    = (r_cnt == CNT_MAX);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign w_push_ok = bus.push & (~w_full | bus.pop);
  assign w_pop_ok  = bus.pop & ~w_empty;

  always_comb begin
    w_cnt_next = r_cnt;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_cnt_next = r_cnt + CNT_ONE;
      2'b01:   w_cnt_next = r_cnt - CNT_ONE;
      default: w_cnt_next = r_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wr_ptr    <= {ADDR_WIDTH{1'b0}};
      r_rd_ptr    <= {ADDR_WIDTH{1'b0}};
      r_cnt       <= {(ADDR_WIDTH+1){1'b0}};
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.clear) begin
      r_wr_ptr    <= {ADDR_WIDTH{1'b0}};
      r_rd_ptr    <= {ADDR_WIDTH{1'b0}};
      r_cnt       <= {(ADDR_WIDTH+1){1'b0}};
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_cnt <= w_cnt_next;
      if (bus.push && !w_push_ok) r_overflow  <= 1'b1;
      if (bus.pop  && !w_pop_ok)  r_underflow <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset and clear; only the pointers matter.
  always_ff @(posedge clk) begin
    if (w_push_ok && !bus.clear) begin
      r_mem[r_wr_ptr] <= bus.data_in;
    end
  end

  assign bus.data_out  = r_mem[r_rd_ptr];
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.size      = r_cnt;
  assign bus.above_thr = (r_cnt > bus.threshold);
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;

endmodule

// File: tb/tb_airi5c_spi_fifo.sv
// Self-checking bench for airi5c_spi_fifo: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_airi5c_spi_fifo;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  airi5c_spi_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
  airi5c_spi_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q[$];
  bit m_ov = 1'b0;
  bit m_un = 1'b0;

  // Drive one cycle of strobes, apply the FIFO rules to the model, return at edge+1.
  task automatic step(input bit p, input logic [DW-1:0] d, input bit po, input bit cl);
    bit pop_acc, push_acc;
    bus.push = p; bus.data_in = d; bus.pop = po; bus.clear = cl;
    @(posedge clk);
    if (cl) begin
      q.delete(); m_ov = 1'b0; m_un = 1'b0;
    end else begin
      pop_acc  = po && (q.size() > 0);
      push_acc = p && ((q.size() < DEPTH) || po);
      if (po && !pop_acc) m_un = 1'b1;
      if (p && !push_acc) m_ov = 1'b1;
      if (pop_acc) void'(q.pop_front());
      if (push_acc) q.push_back(d);
    end
    #1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    bus.push = 1'b0; bus.pop = 1'b0; bus.clear = 1'b0;
    bus.data_in = '0; bus.threshold = '0;
    n_reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    #1;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
    checks++; if (bus.size !== 4'd0) begin errors++; $display("FAIL reset_size: got %0d want 0", bus.size); end
    checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got ov=%b un=%b want 0 0", bus.overflow, bus.underflow); end
    checks++; if (bus.above_thr !== 1'b0) begin errors++; $display("FAIL reset_above: got %b want 0", bus.above_thr); end
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    checks++; if (bus.empty !== 1'b0 || bus.data_out !== 8'hA5 || bus.size !== 4'd1) begin
      errors++; $display("FAIL first_push: got empty=%b data=%h size=%0d want 0 a5 1", bus.empty, bus.data_out, bus.size); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_fill_overflow_wrap();
    for (int r = 0; r < 2; r++) begin
      if (r == 1) begin
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      checks++; if (bus.full !== 1'b1 || bus.size !== 4'd8) begin
        errors++; $display("FAIL fill_r%0d: got full=%b size=%0d want 1 8", r, bus.full, bus.size); end
      step(1'b1, 8'h09, 1'b0, 1'b0);
      checks++; if (bus.overflow !== 1'b1 || bus.size !== 4'd8) begin
        errors++; $display("FAIL overflow_r%0d: got ov=%b size=%0d want 1 8", r, bus.overflow, bus.size); end
      for (int i = 1; i <= 8; i++) begin
        checks++; if (bus.data_out !== 8'(i)) begin
          errors++; $display("FAIL order_r%0d_%0d: got %h want %h", r, i, bus.data_out, 8'(i)); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_r%0d: got empty=%b want 1", r, bus.empty); end
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_full_pushpop();
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    checks++; if (bus.size !== 4'd8 || bus.data_out !== 8'h02 || bus.overflow !== 1'b0 || bus.full !== 1'b1) begin
      errors++; $display("FAIL full_pushpop: got size=%0d head=%h ov=%b full=%b want 8 02 0 1",
                         bus.size, bus.data_out, bus.overflow, bus.full); end
    repeat (7) step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (bus.data_out !== 8'h55 || bus.size !== 4'd1) begin
      errors++; $display("FAIL full_pushpop_tail: got head=%h size=%0d want 55 1", bus.data_out, bus.size); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_empty_boundary();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (bus.underflow !== 1'b1 || bus.size !== 4'd0 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL underflow: got un=%b size=%0d empty=%b want 1 0 1", bus.underflow, bus.size, bus.empty); end
    step(1'b1, 8'h33, 1'b1, 1'b0);
    checks++; if (bus.size !== 4'd1 || bus.data_out !== 8'h33 || bus.underflow !== 1'b1) begin
      errors++; $display("FAIL empty_pushpop: got size=%0d data=%h un=%b want 1 33 1", bus.size, bus.data_out, bus.underflow); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_clear_threshold();
    bus.threshold = 4'd3;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    checks++; if (bus.above_thr !== 1'b0) begin errors++; $display("FAIL thr_equal: got %b want 0", bus.above_thr); end
    step(1'b1, 8'h43, 1'b0, 1'b0);
    checks++; if (bus.above_thr !== 1'b1) begin errors++; $display("FAIL thr_above: got %b want 1", bus.above_thr); end
    step(1'b1, 8'h77, 1'b0, 1'b1);
    checks++; if (bus.size !== 4'd0 || bus.above_thr !== 1'b0 || bus.overflow !== 1'b0 ||
                  bus.underflow !== 1'b0 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL clear_prio: got size=%0d above=%b ov=%b un=%b empty=%b want 0 0 0 0 1",
                         bus.size, bus.above_thr, bus.overflow, bus.underflow, bus.empty); end
  endtask

  task automatic test_async_reset();
    bus.threshold = 4'd3;
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b0);
    checks++; if (bus.size !== 4'd5 || bus.above_thr !== 1'b1) begin
      errors++; $display("FAIL pre_reset: got size=%0d above=%b want 5 1", bus.size, bus.above_thr); end
    #2 n_reset = 1'b0;
    #1;
    checks++; if (bus.empty !== 1'b1 || bus.size !== 4'd0 || bus.full !== 1'b0 || bus.above_thr !== 1'b0 ||
                  bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      errors++; $display("FAIL async_reset: got empty=%b size=%0d full=%b above=%b ov=%b un=%b",
                         bus.empty, bus.size, bus.full, bus.above_thr, bus.overflow, bus.underflow); end
    q.delete(); m_ov = 1'b0; m_un = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    step(1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) begin
      checks++; if (bus.data_out !== 8'(i - 1) || bus.size !== 4'd1) begin
        errors++; $display("FAIL stream_%0d: got head=%h size=%0d want %h 1", i, bus.data_out, bus.size, 8'(i - 1)); end
      step(1'b1, 8'(i), 1'b1, 1'b0);
    end
    checks++; if (bus.data_out !== 8'h0F) begin errors++; $display("FAIL stream_last: got %h want 0f", bus.data_out); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (bus.empty !== 1'b1 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      errors++; $display("FAIL stream_end: got empty=%b ov=%b un=%b want 1 0 0", bus.empty, bus.overflow, bus.underflow); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0) bus.threshold = 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 63) == 0));
      checks++;
      if (bus.size !== 4'(q.size()) || bus.empty !== (q.size() == 0) || bus.full !== (q.size() == DEPTH) ||
          bus.above_thr !== (q.size() > int'(bus.threshold)) || bus.overflow !== m_ov || bus.underflow !== m_un ||
          (q.size() != 0 && bus.data_out !== q[0])) begin
        errors++;
        $display("FAIL random_%0d: got size=%0d head=%h ov=%b un=%b above=%b want size=%0d head=%h ov=%b un=%b thr=%0d",
                 n, bus.size, bus.data_out, bus.overflow, bus.underflow, bus.above_thr,
                 q.size(), (q.size() != 0) ? q[0] : 8'h00, m_ov, m_un, bus.threshold);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow_wrap();
    test_full_pushpop();
    test_empty_boundary();
    test_clear_threshold();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
